// File: rtl/seq_multiplier.sv
// seq_multiplier: 32x32 unsigned shift-add multiplier, 32 steps.
// Ports:
//   i_clk, i_reset (sync, active-high)
//   i_start, i_a, i_b  : request and operands
//   o_prod_hi/o_prod_lo: 64-bit product halves
//   o_busy, o_done     : status, o_done is a 1-cycle pulse
module seq_multiplier (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_prod_lo,
  output logic [31:0] o_prod_hi,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [63:0] r_mcand;
  logic [63:0] r_acc;
  logic [31:0] r_mplier;
  logic [5:0]  r_cnt;
  logic        r_done;
  logic        w_accept;
  logic        w_step;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_step   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next   = S_CALC;
          w_accept = 1'b1;
        end
      end
      S_CALC: begin
        w_step = 1'b1;
        // counter reaches 32 on this edge
        if (r_cnt == 6'd31) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Done is registered so it cannot glitch on the downstream WE
  always_ff @(posedge i_clk) begin
    if (i_reset) r_done <= 1'b0;
    else         r_done <= (w_next == S_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_mcand  <= {32'd0, i_a};
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_step) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= {r_mcand[62:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[31:1]};
      r_cnt    <= r_cnt + 6'd1;
    end
  end

  assign o_prod_lo = r_acc[31:0];
  assign o_prod_hi = r_acc[63:32];
  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = r_done;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed self-checking bench for seq_multiplier.
// Each scenario task drives stimulus and checks results inline.
module tb_seq_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] lo;
  logic [31:0] hi;
  logic        busy;
  logic        done;
  logic [31:0] ds;

  int vec;
  int bad;

  seq_multiplier dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .i_start  (start),
    .i_a      (a),
    .i_b      (b),
    .o_prod_lo(lo),
    .o_prod_hi(hi),
    .o_busy   (busy),
    .o_done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // downstream 32-bit register: Data=Prod_Lo, WE=Done
  always @(posedge clk) begin
    if (rst)       ds <= 32'd0;
    else if (done) ds <= lo;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] xa,
                        input logic [31:0] xb);
    a     = xa;
    b     = xb;
    start = 1'b1;
  endtask

  // n counts edges from the accepting edge (which is n=1)
  task automatic wait_done(output int n);
    n = 0;
    while (n < 100) begin
      tick();
      n++;
      if (n == 1) start = 1'b0;
      if (done) break;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    a     = 32'hFFFF_FFFF;
    b     = 32'hFFFF_FFFF;
    tick();
    tick();
    vec++;
    if (lo !== 32'd0 || hi !== 32'd0) begin
      bad++;
      $display("FAIL reset_prod: got %h_%h want 0", hi, lo);
    end
    vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: busy=%b done=%b want 0 0",
               busy, done);
    end
    start = 1'b0;
    rst   = 1'b0;
    tick();
    vec++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_basic();
    int n;
    launch(32'd3, 32'd5);
    tick();
    start = 1'b0;
    vec++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_busy: busy=%b want 1", busy);
    end
    wait_done(n);
    n++;
    vec++;
    if (n !== 33) begin
      bad++;
      $display("FAIL basic_latency: edges=%0d want 33", n);
    end
    vec++;
    if (hi !== 32'd0 || lo !== 32'd15) begin
      bad++;
      $display("FAIL basic_prod: got %h_%h want 0_f", hi, lo);
    end
    tick();
    vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL basic_after: busy=%b done=%b want 0 0",
               busy, done);
    end
    a = 32'h5555_5555;
    b = 32'hAAAA_AAAA;
    repeat (3) tick();
    vec++;
    if (hi !== 32'd0 || lo !== 32'd15 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_hold: got %h_%h busy=%b want 0_f 0",
               hi, lo, busy);
    end
  endtask

  task automatic test_operands();
    int n;
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n);
    vec++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      bad++;
      $display("FAIL max_prod: got %h_%h want fffffffe_00000001",
               hi, lo);
    end
    tick();
    launch(32'd0, 32'h1234_5678);
    wait_done(n);
    vec++;
    if (n !== 33) begin
      bad++;
      $display("FAIL zero_latency: edges=%0d want 33", n);
    end
    vec++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      bad++;
      $display("FAIL zero_prod: got %h_%h want 0", hi, lo);
    end
    tick();
    launch(32'd1, 32'hDEAD_BEEF);
    wait_done(n);
    vec++;
    if (hi !== 32'd0 || lo !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL ident_prod: got %h_%h want 0_deadbeef",
               hi, lo);
    end
    tick();
    launch(32'h8000_0001, 32'd3);
    wait_done(n);
    vec++;
    if (hi !== 32'd1 || lo !== 32'h8000_0003) begin
      bad++;
      $display("FAIL carry_prod: got %h_%h want 1_80000003",
               hi, lo);
    end
    tick();
  endtask

  task automatic test_busy_ignore();
    int dones;
    int first;
    logic [31:0] plo;
    logic [31:0] phi;
    dones = 0;
    first = 0;
    plo   = '0;
    phi   = '0;
    launch(32'd7, 32'd6);
    for (int n = 1; n <= 90; n++) begin
      tick();
      start = 1'b0;
      if (n == 10) begin
        start = 1'b1;
        a     = 32'd2;
        b     = 32'd2;
      end
      if (n == 11) begin
        a = 32'hCAFE_0000;
        b = 32'h0000_BEEF;
      end
      if (done) begin
        dones++;
        if (first == 0) begin
          first = n;
          plo   = lo;
          phi   = hi;
        end
      end
    end
    vec++;
    if (dones !== 1) begin
      bad++;
      $display("FAIL ignore_count: dones=%0d want 1", dones);
    end
    vec++;
    if (first !== 33) begin
      bad++;
      $display("FAIL ignore_latency: edges=%0d want 33", first);
    end
    vec++;
    if (phi !== 32'd0 || plo !== 32'd42) begin
      bad++;
      $display("FAIL ignore_prod: got %h_%h want 0_2a", phi, plo);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    int n;
    dones = 0;
    launch(32'd100, 32'd100);
    for (int k = 1; k <= 21; k++) begin
      tick();
      start = 1'b0;
      if (done) dones++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vec++;
    if (lo !== 32'd0 || hi !== 32'd0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_out: got %h_%h busy=%b done=%b want 0",
               hi, lo, busy, done);
    end
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) dones++;
    end
    vec++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL mid_reset_done: dones=%0d want 0", dones);
    end
    launch(32'd10, 32'd10);
    wait_done(n);
    vec++;
    if (n !== 33 || lo !== 32'd100 || hi !== 32'd0) begin
      bad++;
      $display("FAIL mid_reset_restart: edges=%0d got %h_%h want 33 0_64",
               n, hi, lo);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int times[$];
    logic prev;
    prev = 1'b0;
    vec++;
    if (ds !== 32'd100) begin
      bad++;
      $display("FAIL b2b_ds_init: ds=%h want 64", ds);
    end
    a     = 32'h0001_0000;
    b     = 32'h0001_0000;
    start = 1'b1;
    for (int n = 1; n <= 120; n++) begin
      tick();
      if (prev) begin
        vec++;
        if (ds !== 32'd0) begin
          bad++;
          $display("FAIL b2b_ds_load: ds=%h want 0", ds);
        end
      end
      if (done) begin
        times.push_back(n);
        vec++;
        if (hi !== 32'd1 || lo !== 32'd0) begin
          bad++;
          $display("FAIL b2b_prod: got %h_%h want 1_0", hi, lo);
        end
        if (times.size() == 1) begin
          vec++;
          if (ds !== 32'd100) begin
            bad++;
            $display("FAIL b2b_ds_hold: ds=%h want 64", ds);
          end
        end
      end
      prev = done;
    end
    start = 1'b0;
    vec++;
    if (times.size() !== 3) begin
      bad++;
      $display("FAIL b2b_count: dones=%0d want 3", times.size());
    end else begin
      vec++;
      if (times[0] !== 33 || times[1] - times[0] !== 34 ||
          times[2] - times[1] !== 34) begin
        bad++;
        $display("FAIL b2b_spacing: at %0d %0d %0d want 33 67 101",
                 times[0], times[1], times[2]);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    vec   = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    test_reset();
    test_basic();
    test_operands();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
